// File: rtl/icache_nway.sv
// N-way set-associative read-only instruction cache with refill FSM,
// invalid-first / round-robin replacement, full flush and saturating counters.

module icache_way #(
  parameter int NrSets       = 64,
  parameter int WordsPerLine = 4,
  parameter int IndexBits    = 6,
  parameter int TagBits      = 22
) (
  input  logic                          clk_i,
  input  logic [IndexBits-1:0]          index,
  input  logic [TagBits-1:0]            tag,
  input  logic [$clog2(WordsPerLine)-1:0] word_sel,
  input  logic                          we,
  input  logic [32*WordsPerLine-1:0]    wdata,
  output logic                          tag_eq,
  output logic [31:0]                   rword
);
  logic [TagBits-1:0]               tag_mem  [NrSets];
  logic [WordsPerLine-1:0][31:0]    data_mem [NrSets];

  always_ff @(posedge clk_i) begin
    if (we) begin
      tag_mem[index]  <= tag;
      data_mem[index] <= wdata;
    end
  end

  assign tag_eq = (tag_mem[index] == tag);
  assign rword  = data_mem[index][word_sel];
endmodule

module icache_nway #(
  parameter int NrWays       = 2,
  parameter int NrSets       = 64,
  parameter int WordsPerLine = 4,
  parameter int OffsetBits   = $clog2(WordsPerLine) + 2,
  parameter int IndexBits    = $clog2(NrSets),
  parameter int TagBits      = 32 - IndexBits - OffsetBits,
  parameter int LineSize     = 32 * WordsPerLine
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [31:0]         addr_i,
  input  logic                read_en_i,
  output logic                read_valid_o,
  output logic [31:0]         read_word_o,
  output logic                busy_o,
  input  logic                flush_i,
  output logic [31:0]         mem_addr_o,
  output logic                mem_read_en_o,
  input  logic                mem_read_valid_i,
  input  logic [LineSize-1:0] mem_read_data_i,
  output logic [31:0]         hit_count_o,
  output logic [31:0]         miss_count_o
);
  localparam int WayBits  = (NrWays > 1) ? $clog2(NrWays) : 1;
  localparam int WordBits = $clog2(WordsPerLine);

  typedef enum logic [1:0] {IDLE, MISS, FLUSH} state_e;
  typedef struct packed {
    logic [WayBits-1:0] way;
    logic               from_rr;
  } victim_t;

  state_e state_q, state_d;
  victim_t victim_q, victim_d;
  logic [NrSets-1:0][NrWays-1:0]  valid_q;
  logic [NrSets-1:0][WayBits-1:0] rr_q;
  logic [IndexBits-1:0]           flush_set_q;
  logic                           flush_pending_q;
  logic [31:0]                    hit_cnt_q, miss_cnt_q;

  logic [TagBits-1:0]          tag;
  logic [IndexBits-1:0]        index;
  logic [WordBits-1:0]         word;
  logic [NrWays-1:0]           tag_eq, hit_vec, way_we;
  logic [NrWays-1:0][31:0]     way_word;
  logic [WordsPerLine-1:0][31:0] mem_words;
  logic [31:0]                 hit_word;
  logic                        hit, refill, hit_inc, miss_inc;
  logic                        unused_addr;

  assign tag         = addr_i[31:32-TagBits];
  assign index       = addr_i[OffsetBits+IndexBits-1:OffsetBits];
  assign word        = addr_i[OffsetBits-1:2];
  assign unused_addr = ^addr_i[1:0];
  assign mem_words   = mem_read_data_i;

  assign way_we = refill ? (NrWays'(1) << victim_q.way) : '0;

  for (genvar w = 0; w < NrWays; w++) begin : g_way
    icache_way #(
      .NrSets(NrSets), .WordsPerLine(WordsPerLine),
      .IndexBits(IndexBits), .TagBits(TagBits)
    ) u_way (
      .clk_i   (clk_i),
      .index   (index),
      .tag     (tag),
      .word_sel(word),
      .we      (way_we[w]),
      .wdata   (mem_read_data_i),
      .tag_eq  (tag_eq[w]),
      .rword   (way_word[w])
    );
  end

  assign hit_vec = valid_q[index] & tag_eq;
  assign hit     = |hit_vec;

  // At most one way matches, so an OR of the masked words selects it.
  always_comb begin
    hit_word = '0;
    for (int w = 0; w < NrWays; w++)
      if (hit_vec[w]) hit_word |= way_word[w];
  end

  always_comb begin
    victim_d.way     = rr_q[index];
    victim_d.from_rr = 1'b1;
    for (int w = NrWays-1; w >= 0; w--) begin
      if (!valid_q[index][w]) begin
        victim_d.way     = WayBits'(w);
        victim_d.from_rr = 1'b0;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    read_valid_o  = 1'b0;
    read_word_o   = '0;
    mem_read_en_o = 1'b0;
    mem_addr_o    = '0;
    refill        = 1'b0;
    hit_inc       = 1'b0;
    miss_inc      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flush_i) begin
          state_d = FLUSH;
        end else if (read_en_i) begin
          if (hit) begin
            read_valid_o = 1'b1;
            read_word_o  = hit_word;
            hit_inc      = 1'b1;
          end else begin
            state_d  = MISS;
            miss_inc = 1'b1;
          end
        end
      end
      MISS: begin
        mem_read_en_o = 1'b1;
        mem_addr_o    = {addr_i[31:OffsetBits], {OffsetBits{1'b0}}};
        if (mem_read_valid_i) begin
          refill       = 1'b1;
          read_valid_o = 1'b1;
          read_word_o  = mem_words[word];
          state_d      = (flush_pending_q || flush_i) ? FLUSH : IDLE;
        end
      end
      FLUSH: begin
        if (flush_set_q == IndexBits'(NrSets-1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      victim_q        <= '0;
      valid_q         <= '0;
      rr_q            <= '0;
      flush_set_q     <= '0;
      flush_pending_q <= 1'b0;
      hit_cnt_q       <= '0;
      miss_cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      if (hit_inc && hit_cnt_q != '1)   hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_inc && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
      if (miss_inc) victim_q <= victim_d;
      if (state_q == MISS && flush_i) flush_pending_q <= 1'b1;
      if (refill) begin
        valid_q[index][victim_q.way] <= 1'b1;
        // Only a round-robin pick moves the pointer; filling a hole does not.
        if (victim_q.from_rr)
          rr_q[index] <= WayBits'((int'(victim_q.way) + 1) % NrWays);
      end
      if (state_q == FLUSH) begin
        valid_q[flush_set_q] <= '0;
        rr_q[flush_set_q]    <= '0;
        flush_set_q          <= flush_set_q + 1'b1;
        if (flush_set_q == IndexBits'(NrSets-1)) flush_pending_q <= 1'b0;
      end
    end
  end

  assign busy_o       = (state_q != IDLE);
  assign hit_count_o  = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;
endmodule

// File: doc/icache_nway.md
Name: icache_nway

Overview:
- Parametrised N-way set-associative, read-only instruction cache.
- Sits between the fetch stage and the line-wide memory port.
- Generalises the fixed 2-way/64-set/4-word cache:
  - configurable ways, sets and line length;
  - explicit refill FSM;
  - invalid-way-first replacement with a per-set round-robin fallback;
  - full-cache flush;
  - saturating hit/miss counters.

Parameters:
- NrWays, 2: associativity; power of two, 1..8.
- NrSets, 64: number of sets; power of two, ≥2.
- WordsPerLine, 4: 32-bit words per line; power of two, ≥2.
- OffsetBits, derived: log2(WordsPerLine)+2.
- IndexBits, derived: log2(NrSets).
- TagBits, derived: 32-IndexBits-OffsetBits.
- LineSize, derived: 32*WordsPerLine.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- addr_i  in  32  fetch byte address; held stable by the requester until read_valid_o.
- read_en_i  in  1  fetch request.
- read_valid_o  out  1  read_word_o valid this cycle.
- read_word_o  out  32  fetched word.
- busy_o  out  1  high in MISS or FLUSH.
- flush_i  in  1  single-cycle pulse requesting invalidation of all lines.
- mem_addr_o  out  32  line-aligned refill address.
- mem_read_en_o  out  1  refill request; level, held until mem_read_valid_i.
- mem_read_valid_i  in  1  refill data valid; single-cycle pulse.
- mem_read_data_i  in  LineSize  refill line; word k at bits [32k+31:32k].
- hit_count_o  out  32  saturating count of hits.
- miss_count_o  out  32  saturating count of misses.

Behaviour:
- Reset (rst_i high, asynchronous):
  - all valid bits and round-robin pointers cleared; state IDLE; flush_pending 0; counters 0;
  - read_valid_o, mem_read_en_o and busy_o 0; read_word_o and mem_addr_o 0.
  - Tag and data arrays need not be reset.
- Address split: tag = addr_i[31:32-TagBits]; index = addr_i[OffsetBits+IndexBits-1:OffsetBits]; word = addr_i[OffsetBits-1:2].
- Hit: any way in the indexed set has valid=1 and a matching tag.
  - Hit detection assumes at most one way matches; a refill never creates a duplicate.
- FSM has three states: IDLE, MISS, FLUSH.
- IDLE, hit:
  - with read_en_i=1, read_valid_o=1 and read_word_o = selected word of the hit way, in the same cycle (combinational);
  - hit_count_o increments.
- IDLE, miss:
  - with read_en_i=1, go to MISS next cycle;
  - miss_count_o increments once per miss (not per stall cycle);
  - victim way latched in that cycle: the lowest-numbered invalid way if any, else rr_ptr[index].
- MISS:
  - mem_read_en_o=1 and mem_addr_o = {addr_i[31:OffsetBits], zeros}; read_valid_o=0.
  - On mem_read_valid_i, the same cycle:
    - write data, tag and valid=1 into the victim way;
    - read_valid_o=1 and read_word_o = forwarded word from mem_read_data_i;
    - rr_ptr[index] advances to victim+1 mod NrWays, only if the victim came from rr_ptr;
    - next state IDLE, or FLUSH if flush_pending.
  - Miss-to-data latency = memory latency + 1 cycle.
- flush_i:
  - In IDLE: go to FLUSH next cycle; any read_en_i that cycle is not served.
  - In MISS: sets flush_pending; the refill completes first (data is returned), then FLUSH.
  - In FLUSH: ignored.
- FLUSH:
  - a set counter walks 0..NrSets-1, clearing all valid bits of one set per cycle and resetting its rr_ptr to 0;
  - exactly NrSets cycles, then IDLE with flush_pending cleared;
  - read_valid_o=0 and mem_read_en_o=0 throughout.
- busy_o = (state != IDLE).
- mem_read_valid_i outside MISS is ignored.
- Counters saturate at 32'hFFFF_FFFF.
- rst_i mid-MISS or mid-FLUSH:
  - immediate return to IDLE; all lines invalid;
  - a late mem_read_valid_i is ignored.
- NrWays=1 degenerates to direct-mapped; rr_ptr is unused.

Test Plan:
- Cold miss, default parameters:
  - Stimulus: reset; read addr 0x0000_1004; memory answers 3 cycles after mem_read_en_o with the line {0x33,0x22,0x11,0x00} (word3..word0).
  - Required: mem_addr_o=0x0000_1000; read_word_o=0x11 on the valid cycle; miss_count=1.
  - Re-read of 0x0000_100C the next cycle: hit the same cycle, word 0x33, hit_count=1.
- Replacement, 2 ways:
  - Stimulus: fill 0x0000_0000 (A) and 0x0000_0400 (B), same set 0; a third tag 0x0000_0800 (C) misses.
  - Required: C replaces way 0 (rr_ptr=0), then rr_ptr=1; A now misses; B still hits.
- Flush during miss:
  - Stimulus: flush_i pulsed while in MISS.
  - Required: refill data is returned; busy_o stays high exactly NrSets=64 cycles after the refill; afterwards the previously cached address misses.
- Reset mid-refill:
  - Stimulus: rst_i asserted in MISS; mem_read_valid_i arrives after reset.
  - Required: no line installed; all outputs 0; the next access misses.
- Parameter sweep:
  - Stimulus: NrWays=4, NrSets=16, WordsPerLine=8; random address stream checked against a reference model.
  - Required: every returned word matches memory; hit+miss counts match the model exactly.
- Counter saturation:
  - Stimulus: force hit_count to 0xFFFF_FFFE; issue 3 hits.
  - Required: the counter holds 0xFFFF_FFFF.
